// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port synchronous SRAM between an instruction-fetch port
//   (I, read-only) and a load/store port (D, read/write). At most one port is
//   granted per cycle; grants are combinational. Read data returns through
//   per-port holding registers two cycles after the grant. D may lock the SRAM
//   for read-modify-write sequences, starving I until the lock is dropped.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : conflicts in ARB go to the port that did not win last.
//     undefined : D always wins conflicts (fixed priority).
//
//   Ports
//     CLK, RESET_N            clock, async active-low reset
//     I_REQ/I_ADDR            fetch request and address
//     I_GNT/I_VALID/I_RDATA   fetch grant, return pulse, held read data
//     D_REQ/D_WE/D_LOCK       data request, write enable, lock request
//     D_ADDR/D_WDATA          data address, write data
//     D_GNT/D_VALID/D_RDATA   data grant, read return pulse, held read data
//     S_ADDR/S_WEN/S_DI/S_DO  SRAM address, write enable, data in, data out
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_ARB  | normal arbitration between I and D
//   ST_LOCKED | D owns the SRAM; I_GNT forced low
module sram_arbiter #(
   parameter int AWIDTH = 10,
   parameter int WIDTH  = 32
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              I_REQ,
   input  logic [AWIDTH-1:0] I_ADDR,
   output logic              I_GNT,
   output logic              I_VALID,
   output logic [WIDTH-1:0]  I_RDATA,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic              D_LOCK,
   input  logic [AWIDTH-1:0] D_ADDR,
   input  logic [WIDTH-1:0]  D_WDATA,
   output logic              D_GNT,
   output logic              D_VALID,
   output logic [WIDTH-1:0]  D_RDATA,
   output logic [AWIDTH-1:0] S_ADDR,
   output logic              S_WEN,
   output logic [WIDTH-1:0]  S_DI,
   input  logic [WIDTH-1:0]  S_DO
);

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t             state_q;
   logic               pend_i_q;
   logic               pend_d_q;
   logic               i_valid_q;
   logic               d_valid_q;
   logic [WIDTH-1:0]   i_rdata_q;
   logic [WIDTH-1:0]   d_rdata_q;
   logic               i_gnt;
   logic               d_gnt;
   logic               d_wins_conflict;

`ifdef ARB_ROUND_ROBIN_EN
   // LAST register: 1 = D won the most recent grant.
   logic               last_d_q;
   assign d_wins_conflict = ~last_d_q;
`else
   assign d_wins_conflict = 1'b1;
`endif

   // Grants are gated by RESET_N so nothing reaches the SRAM during reset.
   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (RESET_N) begin
         if (state_q == ST_LOCKED) begin
            d_gnt = D_REQ;
         end else if (I_REQ && D_REQ) begin
            d_gnt = d_wins_conflict;
            i_gnt = ~d_wins_conflict;
         end else begin
            d_gnt = D_REQ;
            i_gnt = I_REQ;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_ARB;
         pend_i_q  <= 1'b0;
         pend_d_q  <= 1'b0;
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q  <= 1'b1;
`endif
      end else begin
         // Every D grant decides lock ownership: LOCK=1 enters/keeps the
         // locked state, LOCK=0 makes this the final access of the sequence.
         if (d_gnt) begin
            state_q <= D_LOCK ? ST_LOCKED : ST_ARB;
         end
`ifdef ARB_ROUND_ROBIN_EN
         if (i_gnt) begin
            last_d_q <= 1'b0;
         end else if (d_gnt) begin
            last_d_q <= 1'b1;
         end
`endif
         // Stage 1: remember which port owns the SRAM output next cycle.
         pend_i_q  <= i_gnt;
         pend_d_q  <= d_gnt & ~D_WE;
         // Stage 2: capture S_DO only for owned reads; dummy reads are ignored.
         i_valid_q <= pend_i_q;
         d_valid_q <= pend_d_q;
         if (pend_i_q) begin
            i_rdata_q <= S_DO;
         end
         if (pend_d_q) begin
            d_rdata_q <= S_DO;
         end
      end
   end

   assign I_GNT   = i_gnt;
   assign D_GNT   = d_gnt;
   assign I_VALID = i_valid_q;
   assign D_VALID = d_valid_q;
   assign I_RDATA = i_rdata_q;
   assign D_RDATA = d_rdata_q;

   // With no grant the I address drives a harmless dummy read.
   assign S_ADDR  = d_gnt ? D_ADDR : I_ADDR;
   assign S_WEN   = d_gnt & D_WE;
   assign S_DI    = D_WDATA;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        I_REQ;
   logic [9:0]  I_ADDR;
   logic        I_GNT;
   logic        I_VALID;
   logic [31:0] I_RDATA;
   logic        D_REQ;
   logic        D_WE;
   logic        D_LOCK;
   logic [9:0]  D_ADDR;
   logic [31:0] D_WDATA;
   logic        D_GNT;
   logic        D_VALID;
   logic [31:0] D_RDATA;
   logic [9:0]  S_ADDR;
   logic        S_WEN;
   logic [31:0] S_DI;
   logic [31:0] S_DO;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   sram_arbiter #(.AWIDTH(10), .WIDTH(32)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_VALID(I_VALID), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_LOCK(D_LOCK), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
      .S_ADDR(S_ADDR), .S_WEN(S_WEN), .S_DI(S_DI), .S_DO(S_DO)
   );

   always #5 CLK = ~CLK;

   // Behavioural single-port synchronous SRAM; contents preloaded on the first edge.
   logic [31:0] mem [1024];
   bit          mem_init = 1'b0;

   function automatic logic [31:0] init_val(int k);
      if (k == 'h010) return 32'hDEADBEEF;
      if (k == 'h030) return 32'hA5A50030;
      if (k == 'h044) return 32'h44444444;
      return 32'(k) * 32'h9E3779B1;
   endfunction

   always @(posedge CLK) begin
      if (!mem_init) begin
         for (int k = 0; k < 1024; k++) mem[k] <= init_val(k);
         mem_init <= 1'b1;
      end else begin
         if (S_WEN) mem[S_ADDR] <= S_DI;
         S_DO <= mem[S_ADDR];
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic idle();
      I_REQ = 0; D_REQ = 0; D_WE = 0; D_LOCK = 0;
   endtask

   task automatic test_reset();
      RESET_N = 0; I_REQ = 1; I_ADDR = 10'h010;
      D_REQ = 1; D_WE = 1; D_LOCK = 0; D_ADDR = 10'h020; D_WDATA = 32'h0;
      tick(); tick();
      @(negedge CLK);
      checks++; if (I_GNT !== 1'b0) begin errors++; $display("FAIL rst_i_gnt got %b exp 0", I_GNT); end
      checks++; if (D_GNT !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got %b exp 0", D_GNT); end
      checks++; if (S_WEN !== 1'b0) begin errors++; $display("FAIL rst_s_wen got %b exp 0", S_WEN); end
      checks++; if ({I_VALID, D_VALID} !== 2'b00) begin errors++; $display("FAIL rst_valid got %b exp 00", {I_VALID, D_VALID}); end
      checks++; if (I_RDATA !== 32'h0 || D_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", I_RDATA, D_RDATA); end
      idle();
      tick();
      RESET_N = 1;
      tick();
   endtask

   task automatic test_i_read();
      I_REQ = 1; I_ADDR = 10'h010;
      @(negedge CLK);
      checks++; if (I_GNT !== 1'b1 || S_ADDR !== 10'h010) begin errors++; $display("FAIL iread_gnt got %b/%h exp 1/010", I_GNT, S_ADDR); end
      tick(); I_REQ = 0;
      @(negedge CLK);
      checks++; if (I_VALID !== 1'b0) begin errors++; $display("FAIL iread_early_valid got %b exp 0", I_VALID); end
      tick();
      @(negedge CLK);
      checks++; if (I_VALID !== 1'b1 || I_RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL iread_data got %b/%h exp 1/deadbeef", I_VALID, I_RDATA); end
      checks++; if (D_VALID !== 1'b0) begin errors++; $display("FAIL iread_d_valid got %b exp 0", D_VALID); end
      tick();
      @(negedge CLK);
      checks++; if (I_VALID !== 1'b0 || I_RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL iread_pulse got %b/%h exp 0/deadbeef", I_VALID, I_RDATA); end
      tick();
   endtask

   task automatic test_raw();
      D_REQ = 1; D_WE = 1; D_ADDR = 10'h020; D_WDATA = 32'h12345678;
      @(negedge CLK);
      checks++; if (D_GNT !== 1'b1 || S_WEN !== 1'b1) begin errors++; $display("FAIL raw_write got gnt %b wen %b exp 1/1", D_GNT, S_WEN); end
      tick(); D_WE = 0; D_WDATA = 32'hFFFFFFFF;
      @(negedge CLK);
      checks++; if (D_GNT !== 1'b1 || S_WEN !== 1'b0) begin errors++; $display("FAIL raw_read got gnt %b wen %b exp 1/0", D_GNT, S_WEN); end
      tick(); idle();
      @(negedge CLK);
      checks++; if (D_VALID !== 1'b0 || S_WEN !== 1'b0) begin errors++; $display("FAIL raw_n2 got valid %b wen %b exp 0/0", D_VALID, S_WEN); end
      tick();
      @(negedge CLK);
      checks++; if (D_VALID !== 1'b1 || D_RDATA !== 32'h12345678) begin errors++; $display("FAIL raw_data got %b/%h exp 1/12345678", D_VALID, D_RDATA); end
      tick();
      @(negedge CLK);
      checks++; if (D_VALID !== 1'b0) begin errors++; $display("FAIL raw_pulse got %b exp 0", D_VALID); end
      tick();
   endtask

   task automatic test_conflict();
      I_REQ = 1; I_ADDR = 10'h010; D_REQ = 1; D_WE = 0; D_LOCK = 0; D_ADDR = 10'h020;
      for (int k = 0; k < 4; k++) begin
         logic exp_i;
         exp_i = RR ? (k % 2 == 0) : 1'b0;
         @(negedge CLK);
         checks++;
         if (I_GNT !== exp_i || D_GNT !== ~exp_i) begin
            errors++; $display("FAIL conflict_%0d got i %b d %b exp i %b d %b", k, I_GNT, D_GNT, exp_i, ~exp_i);
         end
         tick();
      end
      idle();
      tick(); tick(); tick();
   endtask

   task automatic test_lock();
      I_REQ = 1; I_ADDR = 10'h040;
      @(negedge CLK);
      checks++; if (I_GNT !== 1'b1) begin errors++; $display("FAIL lock_pre got %b exp 1", I_GNT); end
      tick();
      I_ADDR = 10'h044; D_REQ = 1; D_WE = 0; D_LOCK = 1; D_ADDR = 10'h030;
      @(negedge CLK);
      checks++; if (D_GNT !== 1'b1 || I_GNT !== 1'b0) begin errors++; $display("FAIL lock_c0 got d %b i %b exp 1/0", D_GNT, I_GNT); end
      tick(); D_REQ = 0;
      @(negedge CLK);
      checks++; if (I_GNT !== 1'b0 || D_GNT !== 1'b0) begin errors++; $display("FAIL lock_c1 got i %b d %b exp 0/0", I_GNT, D_GNT); end
      tick(); D_REQ = 1; D_WE = 1; D_LOCK = 0; D_WDATA = 32'h0BADF00D;
      @(negedge CLK);
      checks++; if (D_GNT !== 1'b1 || I_GNT !== 1'b0) begin errors++; $display("FAIL lock_c2 got d %b i %b exp 1/0", D_GNT, I_GNT); end
      checks++; if (D_VALID !== 1'b1 || D_RDATA !== 32'hA5A50030) begin errors++; $display("FAIL lock_rd got %b/%h exp 1/a5a50030", D_VALID, D_RDATA); end
      tick(); D_REQ = 0; D_WE = 0;
      @(negedge CLK);
      checks++; if (I_GNT !== 1'b1) begin errors++; $display("FAIL lock_release got %b exp 1", I_GNT); end
      tick(); idle();
      tick(); tick(); tick();
   endtask

   task automatic test_dummy_isolation();
      for (int k = 0; k < 5; k++) begin
         I_ADDR = 10'($urandom_range(0, 1023));
         @(negedge CLK);
         checks++;
         if (I_VALID !== 1'b0 || D_VALID !== 1'b0 || I_RDATA !== 32'h44444444 || D_RDATA !== 32'hA5A50030) begin
            errors++; $display("FAIL dummy_%0d got v %b%b i %h d %h exp 00 44444444 a5a50030", k, I_VALID, D_VALID, I_RDATA, D_RDATA);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      D_REQ = 1; D_WE = 0; D_LOCK = 1; D_ADDR = 10'h030;
      @(negedge CLK);
      checks++; if (D_GNT !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", D_GNT); end
      tick();
      RESET_N = 0; I_REQ = 1; D_WE = 1;
      #1;
      checks++; if (I_GNT !== 1'b0 || D_GNT !== 1'b0 || S_WEN !== 1'b0) begin errors++; $display("FAIL rmid_gnts got %b%b%b exp 000", I_GNT, D_GNT, S_WEN); end
      checks++; if (I_RDATA !== 32'h0 || D_RDATA !== 32'h0) begin errors++; $display("FAIL rmid_rdata got %h/%h exp 0/0", I_RDATA, D_RDATA); end
      tick();
      @(negedge CLK);
      checks++; if (D_VALID !== 1'b0 || I_VALID !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b%b exp 00", I_VALID, D_VALID); end
      tick();
      RESET_N = 1; D_WE = 0; D_LOCK = 0; I_ADDR = 10'h010;
      D_REQ = RR;   // RR: first conflict goes to I; fixed priority: I alone must get past the released lock
      @(negedge CLK);
      checks++; if (I_GNT !== 1'b1 || D_GNT !== 1'b0) begin errors++; $display("FAIL rmid_after got i %b d %b exp 1/0", I_GNT, D_GNT); end
      tick(); idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         checks++; if (D_VALID !== 1'b0) begin errors++; $display("FAIL rmid_dvalid_%0d got %b exp 0", k, D_VALID); end
         tick();
      end
   endtask

   typedef struct {
      int          due;
      bit          is_d;
      logic [31:0] data;
   } rd_t;

   task automatic test_random();
      rd_t         q[$];
      logic [31:0] mm [1024];
      bit          m_locked = 0;
      bit          m_last_d = 1;
      bit          pi = 0, pd = 0;
      logic [31:0] exp_ir = 0, exp_dr = 0;
      idle();
      RESET_N = 0; tick(); RESET_N = 1;
      for (int k = 0; k < 1024; k++) mm[k] = mem[k];
      for (int n = 0; n < 400; n++) begin
         bit eig, edg, eiv, edv;
         logic [9:0] eaddr;
         if (!I_REQ || pi) begin
            I_REQ = ($urandom_range(0, 2) != 0); I_ADDR = 10'($urandom_range(0, 15));
         end
         if (!D_REQ || pd) begin
            D_REQ = ($urandom_range(0, 2) != 0); D_WE = 1'($urandom_range(0, 1));
            D_LOCK = ($urandom_range(0, 3) == 0); D_ADDR = 10'($urandom_range(0, 15));
            D_WDATA = $urandom;
         end
         @(negedge CLK);
         if (m_locked) begin
            edg = D_REQ; eig = 0;
         end else if (I_REQ && D_REQ) begin
            edg = RR ? !m_last_d : 1'b1; eig = !edg;
         end else begin
            edg = D_REQ; eig = I_REQ;
         end
         eiv = 0; edv = 0;
         while (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].is_d) begin edv = 1; exp_dr = q[0].data; end
            else begin eiv = 1; exp_ir = q[0].data; end
            void'(q.pop_front());
         end
         eaddr = edg ? D_ADDR : I_ADDR;
         checks++;
         if (I_GNT !== eig || D_GNT !== edg || S_WEN !== (edg & D_WE) || S_ADDR !== eaddr) begin
            errors++; $display("FAIL rand_gnt c%0d got i%b d%b w%b a%h exp i%b d%b w%b a%h", cyc, I_GNT, D_GNT, S_WEN, S_ADDR, eig, edg, edg & D_WE, eaddr);
         end
         checks++;
         if (I_VALID !== eiv || D_VALID !== edv || I_RDATA !== exp_ir || D_RDATA !== exp_dr) begin
            errors++; $display("FAIL rand_ret c%0d got v%b%b i%h d%h exp v%b%b i%h d%h", cyc, I_VALID, D_VALID, I_RDATA, D_RDATA, eiv, edv, exp_ir, exp_dr);
         end
         if (edg) begin
            if (D_WE) mm[D_ADDR] = D_WDATA;
            else q.push_back('{due: cyc + 2, is_d: 1'b1, data: mm[D_ADDR]});
            m_locked = D_LOCK; m_last_d = 1;
         end
         if (eig) begin
            q.push_back('{due: cyc + 2, is_d: 1'b0, data: mm[I_ADDR]});
            m_last_d = 0;
         end
         pi = eig; pd = edg;
         tick();
      end
      idle();
      tick(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_raw();
      test_conflict();
      test_lock();
      test_dummy_isolation();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
